// File: rtl/ctrl_hazard_pipe.sv
// ctrl_hazard_pipe: carries decoded control through ID/EX, EX/MEM, MEM/WB and resolves stalls, flushes and forwarding
module ctrl_hazard_pipe #(
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3,
  parameter int BR_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              MemReadD,
  input  logic              ALUSrcD,
  input  logic              ResultSrcD,
  input  logic [BR_W-1:0]   BranchD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [RA_W-1:0]   Rs1D,
  input  logic [RA_W-1:0]   Rs2D,
  input  logic [RA_W-1:0]   RdD,
  input  logic              BranchTakenE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              MemReadE,
  output logic              ALUSrcE,
  output logic              ResultSrcE,
  output logic [BR_W-1:0]   BranchE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [RA_W-1:0]   Rs1E,
  output logic [RA_W-1:0]   Rs2E,
  output logic [RA_W-1:0]   RdE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemReadM,
  output logic              ResultSrcM,
  output logic [RA_W-1:0]   RdM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [RA_W-1:0]   RdW
);
  logic lw_stall;
  // load-use stall (a taken branch overrides it), flushes and EX operand selects with MEM over WB priority
  always_comb begin
    lw_stall  = MemReadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
    StallF    = lw_stall & ~BranchTakenE;
    StallD    = StallF;
    FlushD    = BranchTakenE;
    FlushE    = lw_stall | BranchTakenE;
    ForwardAE = (RegWriteM && RdM != '0 && RdM == Rs1E) ? 2'b10 :
                (RegWriteW && RdW != '0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != '0 && RdM == Rs2E) ? 2'b10 :
                (RegWriteW && RdW != '0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  end
  // ID/EX takes a zero bubble on flush or stall; EX/MEM and MEM/WB advance every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      MemReadE    <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= '0;
      ALUControlE <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      MemReadM    <= 1'b0;
      ResultSrcM  <= 1'b0;
      RdM         <= '0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RdW         <= '0;
    end else begin
      RegWriteE   <= RegWriteD & ~FlushE;
      MemWriteE   <= MemWriteD & ~FlushE;
      MemReadE    <= MemReadD & ~FlushE;
      ALUSrcE     <= ALUSrcD & ~FlushE;
      ResultSrcE  <= ResultSrcD & ~FlushE;
      BranchE     <= FlushE ? '0 : BranchD;
      ALUControlE <= FlushE ? '0 : ALUControlD;
      Rs1E        <= FlushE ? '0 : Rs1D;
      Rs2E        <= FlushE ? '0 : Rs2D;
      RdE         <= FlushE ? '0 : RdD;
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      MemReadM    <= MemReadE;
      ResultSrcM  <= ResultSrcE;
      RdM         <= RdE;
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RdW         <= RdM;
    end
  end
endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// tb_ctrl_hazard_pipe: table-driven directed vectors for the control pipeline and hazard unit
module tb_ctrl_hazard_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic RegWriteD, MemWriteD, MemReadD, ALUSrcD, ResultSrcD;
  logic [2:0] BranchD, ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic BranchTakenE;
  logic StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic RegWriteE, MemWriteE, MemReadE, ALUSrcE, ResultSrcE;
  logic [2:0] BranchE, ALUControlE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic RegWriteM, MemWriteM, MemReadM, ResultSrcM;
  logic [4:0] RdM;
  logic RegWriteW, ResultSrcW;
  logic [4:0] RdW;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ctrl_hazard_pipe #(.RA_W(5), .ALUC_W(3), .BR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemReadD(MemReadD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW)
  );

  // ctl = {RegWrite, MemWrite, MemRead, ALUSrc, ResultSrc, Branch[2:0], ALUControl[2:0]}
  // mctl = {RegWrite, MemWrite, MemRead, ResultSrc}, wctl = {RegWrite, ResultSrc}
  // haz = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}, sampled before the edge
  typedef struct {
    logic        rst;
    logic [10:0] ctl;
    logic [4:0]  rs1, rs2, rd;
    logic        bt;
    logic [7:0]  haz;
    logic [10:0] ectl;
    logic [4:0]  ers1, ers2, erd;
    logic [3:0]  mctl;
    logic [4:0]  mrd;
    logic [1:0]  wctl;
    logic [4:0]  wrd;
  } vec_t;

  localparam logic [10:0] NOP = 11'h000;
  localparam logic [10:0] ADD = 11'h402;
  localparam logic [10:0] LD  = 11'h5C0;
  localparam logic [10:0] ST  = 11'h200;
  localparam logic [10:0] BR  = 11'h009;

  vec_t vt[29];

  function automatic vec_t mk(logic r, logic [10:0] c, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                              logic t, logic [7:0] h, logic [10:0] ec, logic [4:0] e1, logic [4:0] e2,
                              logic [4:0] ed, logic [3:0] mc, logic [4:0] md, logic [1:0] wc, logic [4:0] wd);
    vec_t v;
    v.rst = r; v.ctl = c; v.rs1 = a; v.rs2 = b; v.rd = d; v.bt = t; v.haz = h;
    v.ectl = ec; v.ers1 = e1; v.ers2 = e2; v.erd = ed; v.mctl = mc; v.mrd = md; v.wctl = wc; v.wrd = wd;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
  endtask

  task automatic drive(vec_t v);
    rst_n = v.rst;
    {RegWriteD, MemWriteD, MemReadD, ALUSrcD, ResultSrcD, BranchD, ALUControlD} = v.ctl;
    Rs1D = v.rs1;
    Rs2D = v.rs2;
    RdD = v.rd;
    BranchTakenE = v.bt;
  endtask

  initial begin
    // reset held with a nonzero bundle, then latency, load-use, forwarding, x0, branch and reset cases
    vt[0]  = mk(0, ADD, 1, 2, 3,  0, 8'h00, NOP, 0, 0, 0,  4'h0, 0,  2'h0, 0);
    vt[1]  = mk(1, ADD, 1, 2, 5,  0, 8'h00, ADD, 1, 2, 5,  4'h0, 0,  2'h0, 0);
    vt[2]  = mk(1, NOP, 0, 0, 0,  0, 8'h00, NOP, 0, 0, 0,  4'h8, 5,  2'h0, 0);
    vt[3]  = mk(1, NOP, 0, 0, 0,  0, 8'h00, NOP, 0, 0, 0,  4'h0, 0,  2'h2, 5);
    vt[4]  = mk(1, LD,  1, 0, 7,  0, 8'h00, LD,  1, 0, 7,  4'h0, 0,  2'h0, 0);
    vt[5]  = mk(1, ADD, 7, 2, 8,  0, 8'hD0, NOP, 0, 0, 0,  4'hB, 7,  2'h0, 0);
    vt[6]  = mk(1, ADD, 7, 2, 8,  0, 8'h00, ADD, 7, 2, 8,  4'h0, 0,  2'h3, 7);
    vt[7]  = mk(1, NOP, 0, 0, 0,  0, 8'h04, NOP, 0, 0, 0,  4'h8, 8,  2'h0, 0);
    vt[8]  = mk(1, ADD, 0, 0, 3,  0, 8'h00, ADD, 0, 0, 3,  4'h0, 0,  2'h2, 8);
    vt[9]  = mk(1, ADD, 0, 0, 3,  0, 8'h00, ADD, 0, 0, 3,  4'h8, 3,  2'h0, 0);
    vt[10] = mk(1, ADD, 3, 3, 9,  0, 8'h00, ADD, 3, 3, 9,  4'h8, 3,  2'h2, 3);
    vt[11] = mk(1, NOP, 0, 0, 0,  0, 8'h0A, NOP, 0, 0, 0,  4'h8, 9,  2'h2, 3);
    vt[12] = mk(1, ADD, 0, 0, 3,  0, 8'h00, ADD, 0, 0, 3,  4'h0, 0,  2'h2, 9);
    vt[13] = mk(1, ST,  0, 0, 3,  0, 8'h00, ST,  0, 0, 3,  4'h8, 3,  2'h0, 0);
    vt[14] = mk(1, ADD, 3, 3, 10, 0, 8'h00, ADD, 3, 3, 10, 4'h4, 3,  2'h2, 3);
    vt[15] = mk(1, NOP, 0, 0, 0,  0, 8'h05, NOP, 0, 0, 0,  4'h8, 10, 2'h0, 3);
    vt[16] = mk(1, LD,  0, 0, 0,  0, 8'h00, LD,  0, 0, 0,  4'h0, 0,  2'h2, 10);
    vt[17] = mk(1, ADD, 0, 0, 0,  0, 8'h00, ADD, 0, 0, 0,  4'hB, 0,  2'h0, 0);
    vt[18] = mk(1, NOP, 0, 0, 0,  0, 8'h00, NOP, 0, 0, 0,  4'h8, 0,  2'h3, 0);
    vt[19] = mk(1, LD,  0, 0, 4,  0, 8'h00, LD,  0, 0, 4,  4'h0, 0,  2'h2, 0);
    vt[20] = mk(1, ADD, 0, 4, 6,  1, 8'h30, NOP, 0, 0, 0,  4'hB, 4,  2'h0, 0);
    vt[21] = mk(1, BR,  1, 2, 0,  1, 8'h30, NOP, 0, 0, 0,  4'h0, 0,  2'h3, 4);
    vt[22] = mk(1, ADD, 1, 2, 11, 0, 8'h00, ADD, 1, 2, 11, 4'h0, 0,  2'h0, 0);
    vt[23] = mk(1, ADD, 1, 2, 12, 0, 8'h00, ADD, 1, 2, 12, 4'h8, 11, 2'h0, 0);
    vt[24] = mk(1, ADD, 1, 2, 13, 0, 8'h00, ADD, 1, 2, 13, 4'h8, 12, 2'h2, 11);
    vt[25] = mk(0, ADD, 1, 2, 14, 0, 8'h00, NOP, 0, 0, 0,  4'h0, 0,  2'h0, 0);
    vt[26] = mk(0, ADD, 1, 2, 3,  1, 8'h30, NOP, 0, 0, 0,  4'h0, 0,  2'h0, 0);
    vt[27] = mk(1, BR,  1, 2, 0,  0, 8'h00, BR,  1, 2, 0,  4'h0, 0,  2'h0, 0);
    vt[28] = mk(1, NOP, 0, 0, 0,  0, 8'h00, NOP, 0, 0, 0,  4'h0, 0,  2'h0, 0);
    drive(vt[0]);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk("hazard", i, {24'd0, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}, {24'd0, vt[i].haz});
      @(posedge clk);
      #1;
      chk("id_ex", i,
          {6'd0, RegWriteE, MemWriteE, MemReadE, ALUSrcE, ResultSrcE, BranchE, ALUControlE, Rs1E, Rs2E, RdE},
          {6'd0, vt[i].ectl, vt[i].ers1, vt[i].ers2, vt[i].erd});
      chk("ex_mem", i, {23'd0, RegWriteM, MemWriteM, MemReadM, ResultSrcM, RdM}, {23'd0, vt[i].mctl, vt[i].mrd});
      chk("mem_wb", i, {25'd0, RegWriteW, ResultSrcW, RdW}, {25'd0, vt[i].wctl, vt[i].wrd});
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
